// File: rtl/inert_sched.sv
// Bring-up and streaming sequencer for the 6-axis inertial sensor behind the SPI monarch.
// Checks WHO_AM_I with retries, writes two config registers, then reads gyro rates on every INT.
module inert_sched #(
    parameter int POR_BITS  = 16,
    parameter int MAX_RETRY = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               INT,
    input  logic               done,
    input  logic        [15:0] rd_data,
    output logic               wrt,
    output logic        [15:0] cmd,
    output logic signed [15:0] ptch_rt,
    output logic signed [15:0] roll_rt,
    output logic signed [15:0] yaw_rt,
    output logic               vld,
    output logic               rdy,
    output logic               err
);

    localparam int RETRY_W = $clog2(MAX_RETRY + 1);

    localparam logic [15:0] CMD_WHO_AM_I = 16'h8F00;
    localparam logic [15:0] CMD_CFG1     = 16'h0D02;
    localparam logic [15:0] CMD_CFG2     = 16'h1160;
    localparam logic [7:0]  SENSOR_ID    = 8'h6A;

    typedef enum logic [3:0] {
        POR_WAIT, ID_RD, CFG1, CFG2, WAIT_INT,
        PL, PH, RL, RH, YL, YH, UPD, HALT
    } state_t;

    state_t               state, nxt_state;
    logic                 int_ff1, int_ff2;
    logic [POR_BITS-1:0]  wait_cnt, wait_cnt_nxt;
    logic [RETRY_W-1:0]   retry_cnt, retry_nxt, retry_inc;
    logic [15:0]          ptch_hold, roll_hold, yaw_hold;
    logic [15:0]          ptch_hold_nxt, roll_hold_nxt, yaw_hold_nxt;
    logic signed [15:0]   ptch_nxt, roll_nxt, yaw_nxt;
    logic [15:0]          cmd_nxt;
    logic                 wrt_nxt, vld_nxt, rdy_nxt, err_nxt;
    logic                 unused_rd_hi;

    // Only the low byte of each SPI response carries sensor data.
    assign unused_rd_hi = ^rd_data[15:8];
    assign retry_inc    = retry_cnt + 1'b1;

    // INT comes from the sensor clock domain, so it is synchronised before use.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            int_ff1 <= 1'b0;
            int_ff2 <= 1'b0;
        end else begin
            int_ff1 <= INT;
            int_ff2 <= int_ff1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= POR_WAIT;
            wait_cnt  <= '0;
            retry_cnt <= '0;
            ptch_hold <= '0;
            roll_hold <= '0;
            yaw_hold  <= '0;
            ptch_rt   <= '0;
            roll_rt   <= '0;
            yaw_rt    <= '0;
            wrt       <= 1'b0;
            cmd       <= '0;
            vld       <= 1'b0;
            rdy       <= 1'b0;
            err       <= 1'b0;
        end else begin
            state     <= nxt_state;
            wait_cnt  <= wait_cnt_nxt;
            retry_cnt <= retry_nxt;
            ptch_hold <= ptch_hold_nxt;
            roll_hold <= roll_hold_nxt;
            yaw_hold  <= yaw_hold_nxt;
            ptch_rt   <= ptch_nxt;
            roll_rt   <= roll_nxt;
            yaw_rt    <= yaw_nxt;
            wrt       <= wrt_nxt;
            cmd       <= cmd_nxt;
            vld       <= vld_nxt;
            rdy       <= rdy_nxt;
            err       <= err_nxt;
        end
    end

    // Every output is registered, so a launch decided here appears as wrt one cycle later.
    always_comb begin
        nxt_state     = state;
        wait_cnt_nxt  = wait_cnt;
        retry_nxt     = retry_cnt;
        ptch_hold_nxt = ptch_hold;
        roll_hold_nxt = roll_hold;
        yaw_hold_nxt  = yaw_hold;
        ptch_nxt      = ptch_rt;
        roll_nxt      = roll_rt;
        yaw_nxt       = yaw_rt;
        wrt_nxt       = 1'b0;
        cmd_nxt       = cmd;
        vld_nxt       = 1'b0;
        rdy_nxt       = rdy;
        err_nxt       = err;

        case (state)
            POR_WAIT: begin
                wait_cnt_nxt = wait_cnt + 1'b1;
                if (&wait_cnt) begin
                    wrt_nxt   = 1'b1;
                    cmd_nxt   = CMD_WHO_AM_I;
                    nxt_state = ID_RD;
                end
            end
            ID_RD: begin
                if (done) begin
                    if (rd_data[7:0] == SENSOR_ID) begin
                        wrt_nxt   = 1'b1;
                        cmd_nxt   = CMD_CFG1;
                        nxt_state = CFG1;
                    end else begin
                        retry_nxt    = retry_inc;
                        wait_cnt_nxt = '0;
                        if (retry_inc == RETRY_W'(MAX_RETRY)) begin
                            err_nxt   = 1'b1;
                            nxt_state = HALT;
                        end else begin
                            nxt_state = POR_WAIT;
                        end
                    end
                end
            end
            CFG1: begin
                if (done) begin
                    wrt_nxt   = 1'b1;
                    cmd_nxt   = CMD_CFG2;
                    nxt_state = CFG2;
                end
            end
            CFG2: begin
                if (done) begin
                    rdy_nxt   = 1'b1;
                    nxt_state = WAIT_INT;
                end
            end
            // Level-sensitive: an INT still high after a sequence starts the next one at once.
            WAIT_INT: begin
                if (int_ff2) begin
                    wrt_nxt   = 1'b1;
                    cmd_nxt   = 16'hA200;
                    nxt_state = PL;
                end
            end
            PL: begin
                if (done) begin
                    ptch_hold_nxt[7:0] = rd_data[7:0];
                    wrt_nxt            = 1'b1;
                    cmd_nxt            = 16'hA300;
                    nxt_state          = PH;
                end
            end
            PH: begin
                if (done) begin
                    ptch_hold_nxt[15:8] = rd_data[7:0];
                    wrt_nxt             = 1'b1;
                    cmd_nxt             = 16'hA400;
                    nxt_state           = RL;
                end
            end
            RL: begin
                if (done) begin
                    roll_hold_nxt[7:0] = rd_data[7:0];
                    wrt_nxt            = 1'b1;
                    cmd_nxt            = 16'hA500;
                    nxt_state          = RH;
                end
            end
            RH: begin
                if (done) begin
                    roll_hold_nxt[15:8] = rd_data[7:0];
                    wrt_nxt             = 1'b1;
                    cmd_nxt             = 16'hA600;
                    nxt_state           = YL;
                end
            end
            YL: begin
                if (done) begin
                    yaw_hold_nxt[7:0] = rd_data[7:0];
                    wrt_nxt           = 1'b1;
                    cmd_nxt           = 16'hA700;
                    nxt_state         = YH;
                end
            end
            YH: begin
                if (done) begin
                    yaw_hold_nxt[15:8] = rd_data[7:0];
                    nxt_state          = UPD;
                end
            end
            // All three rates move together so consumers never see a mixed sample.
            UPD: begin
                ptch_nxt  = ptch_hold;
                roll_nxt  = roll_hold;
                yaw_nxt   = yaw_hold;
                vld_nxt   = 1'b1;
                nxt_state = WAIT_INT;
            end
            HALT: begin
                nxt_state = HALT;
            end
            default: begin
                nxt_state = POR_WAIT;
            end
        endcase
    end

endmodule

// File: tb/tb_inert_sched.sv
// Randomized bench for inert_sched: the bench plays the SPI monarch and the sensor,
// predicting the command stream, timing and published rates from the sequencer's rules.
module tb_inert_sched;

    localparam int          MAX_RETRY_TB = 3;
    localparam logic [6:0]  RATE_BASE    = 7'h22;

    logic               clk;
    logic               rst;
    logic               INT;
    logic               done;
    logic        [15:0] rd_data;
    logic               wrt;
    logic        [15:0] cmd;
    logic signed [15:0] ptch_rt, roll_rt, yaw_rt;
    logic               vld, rdy, err;

    int          total = 0;
    int          bad = 0;
    int          atomic_viol = 0;
    int          rst_wrt_viol = 0;
    logic [15:0] exp_p, exp_r, exp_y;
    logic [47:0] prev_rates;

    inert_sched #(.POR_BITS(4), .MAX_RETRY(MAX_RETRY_TB)) dut (
        .clk(clk), .rst(rst), .INT(INT), .done(done), .rd_data(rd_data),
        .wrt(wrt), .cmd(cmd), .ptch_rt(ptch_rt), .roll_rt(roll_rt), .yaw_rt(yaw_rt),
        .vld(vld), .rdy(rdy), .err(err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Published rates may only move in the cycle vld is high; wrt must stay low under reset.
    always @(negedge clk) begin
        if (rst === 1'b0 && vld !== 1'b1 && {ptch_rt, roll_rt, yaw_rt} !== prev_rates)
            atomic_viol++;
        if (rst === 1'b1 && wrt !== 1'b0)
            rst_wrt_viol++;
        prev_rates = {ptch_rt, roll_rt, yaw_rt};
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] expv);
        total++;
        if (got !== expv) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, expv);
        end
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_wrt"}, wrt, 0);
        checkOutput({tag, "_cmd"}, cmd, 16'h0000);
        checkOutput({tag, "_ptch"}, $unsigned(ptch_rt), 16'h0000);
        checkOutput({tag, "_roll"}, $unsigned(roll_rt), 16'h0000);
        checkOutput({tag, "_yaw"}, $unsigned(yaw_rt), 16'h0000);
        checkOutput({tag, "_vld"}, vld, 0);
        checkOutput({tag, "_rdy"}, rdy, 0);
        checkOutput({tag, "_err"}, err, 0);
    endtask

    task automatic doReset();
        @(negedge clk);
        rst = 1'b1; INT = 1'b0; done = 1'b0; rd_data = '0;
        exp_p = '0; exp_r = '0; exp_y = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    // One SPI transaction: wait for the launch, check it, hold done off, then answer.
    task automatic serviceTxn(input logic [15:0] exp_cmd, input logic [15:0] resp,
                              input int delay, input int exp_lat, input string tag);
        int lat;
        int extra;
        logic [15:0] held;
        lat = 0;
        while (!wrt && lat < 400) begin
            @(negedge clk);
            lat++;
        end
        if (!wrt) begin
            checkOutput({tag, "_wrt_seen"}, wrt, 1);
            return;
        end
        if (exp_lat >= 0) checkOutput({tag, "_lat"}, lat, exp_lat);
        checkOutput({tag, "_cmd"}, cmd, exp_cmd);
        held  = cmd;
        extra = 0;
        for (int i = 0; i <= delay; i++) begin
            @(negedge clk);
            if (wrt || cmd != held) extra++;
        end
        checkOutput({tag, "_quiet"}, extra, 0);
        done = 1'b1; rd_data = resp;
        @(negedge clk);
        done = 1'b0; rd_data = 16'($urandom);
    endtask

    // Bring-up with n_bad wrong IDs before the right one; each retry costs a full 16-cycle wait.
    task automatic doStartup(input int n_bad);
        logic [7:0] idb;
        for (int k = 0; k <= n_bad; k++) begin
            if (k < n_bad) begin
                idb = 8'($urandom);
                if (idb == 8'h6A) idb = 8'h6B;
            end else begin
                idb = 8'h6A;
            end
            serviceTxn(16'h8F00, {8'($urandom), idb}, $urandom_range(0, 3), 16, "id");
            checkOutput("id_err", err, 0);
        end
        checkOutput("rdy_before_cfg", rdy, 0);
        serviceTxn(16'h0D02, 16'($urandom), $urandom_range(0, 3), 0, "cfg1");
        checkOutput("rdy_mid_cfg", rdy, 0);
        serviceTxn(16'h1160, 16'($urandom), $urandom_range(0, 3), 0, "cfg2");
        checkOutput("rdy_after_cfg", rdy, 1);
    endtask

    // Full six-register rate read; sensor drops INT on the first read unless keep_int is set.
    task automatic applyStimulus(input logic [47:0] bytes, input int first_lat,
                                 input bit keep_int, input int slow_idx);
        int lat;
        for (int i = 0; i < 6; i++) begin
            serviceTxn({1'b1, 7'(RATE_BASE + 7'(i)), 8'h00}, {8'($urandom), bytes[8*i +: 8]},
                       (i == slow_idx) ? 50 : int'($urandom_range(0, 3)),
                       (i == 0) ? first_lat : 0, "rate_rd");
            if (i == 0 && !keep_int) INT = 1'b0;
        end
        checkOutput("ptch_held", $unsigned(ptch_rt), exp_p);
        lat = 0;
        while (!vld && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        checkOutput("vld_lat", lat, 1);
        exp_p = bytes[15:0];
        exp_r = bytes[31:16];
        exp_y = bytes[47:32];
        checkOutput("ptch", $unsigned(ptch_rt), exp_p);
        checkOutput("roll", $unsigned(roll_rt), exp_r);
        checkOutput("yaw", $unsigned(yaw_rt), exp_y);
        @(negedge clk);
        checkOutput("vld_pulse", vld, 0);
    endtask

    function automatic logic [47:0] randBytes();
        return {16'($urandom), 32'($urandom)};
    endfunction

    initial begin
        int extra;
        int lat;
        rst = 1'b1; INT = 1'b0; done = 1'b0; rd_data = '0;
        exp_p = '0; exp_r = '0; exp_y = '0;
        repeat (2) @(negedge clk);
        checkResetState("reset");
        rst = 1'b0;

        doStartup(0);

        // A done while nothing is outstanding must not launch anything.
        done = 1'b1; rd_data = 16'($urandom);
        @(negedge clk);
        done = 1'b0;
        extra = 0;
        repeat (10) begin
            @(negedge clk);
            if (wrt || cmd != 16'h1160) extra++;
        end
        checkOutput("spurious_done", extra, 0);

        INT = 1'b1;
        applyStimulus(48'h9A_BC_56_78_12_34, 3, 1'b0, -1);
        checkOutput("yaw_sign", yaw_rt < 0, 1);

        repeat (5) @(negedge clk);
        INT = 1'b1;
        applyStimulus(randBytes(), 3, 1'b0, 3);

        // INT held high: sequences run back to back, one vld each.
        repeat (5) @(negedge clk);
        INT = 1'b1;
        applyStimulus(randBytes(), 3, 1'b1, -1);
        applyStimulus(randBytes(), 0, 1'b1, -1);
        applyStimulus(randBytes(), 0, 1'b0, -1);
        extra = 0;
        repeat (20) begin
            @(negedge clk);
            if (wrt || vld) extra++;
        end
        checkOutput("idle_after_int_drop", extra, 0);

        for (int n = 0; n < 4; n++) begin
            repeat ($urandom_range(2, 8)) @(negedge clk);
            INT = 1'b1;
            applyStimulus(randBytes(), 3, 1'b0, int'($urandom_range(0, 9)) - 4);
        end

        // Reset in the middle of the pitch-high read.
        INT = 1'b1;
        serviceTxn(16'hA200, {8'h00, 8'h55}, 1, 3, "pl");
        INT = 1'b0;
        lat = 0;
        while (!wrt && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        checkOutput("ph_cmd", cmd, 16'hA300);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        checkResetState("mid_rst");
        exp_p = '0; exp_r = '0; exp_y = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        doStartup(2);
        INT = 1'b1;
        applyStimulus(randBytes(), 3, 1'b0, -1);

        // Persistent wrong ID ends in a sticky error with the bus silent.
        doReset();
        for (int k = 0; k < MAX_RETRY_TB; k++) begin
            serviceTxn(16'h8F00, {8'($urandom), 8'h00}, $urandom_range(0, 3), 16, "id_bad");
            checkOutput("err_after_bad", err, (k + 1 >= MAX_RETRY_TB));
        end
        checkOutput("rdy_halt", rdy, 0);
        INT = 1'b1;
        extra = 0;
        repeat (60) begin
            @(negedge clk);
            if (wrt) extra++;
        end
        checkOutput("halt_quiet", extra, 0);
        checkOutput("err_sticky", err, 1);
        checkOutput("rdy_halt_end", rdy, 0);

        checkOutput("atomic_update", atomic_viol, 0);
        checkOutput("no_wrt_in_rst", rst_wrt_viol, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
